// File: rtl/key_debouncer_if.sv
// Pushbutton debouncer signal bundle: raw key in, debounced level/strobes out.
// glitch_cnt exists only when KEY_DEBOUNCE_GLITCH_CNT_EN is defined.
interface key_debouncer_if;
    logic       key_raw;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       busy;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output key_raw,
                    input  key_level, press_pulse, release_pulse, busy, glitch_cnt);
    modport slave  (input  key_raw,
                    output key_level, press_pulse, release_pulse, busy, glitch_cnt);
`else
    modport master (output key_raw,
                    input  key_level, press_pulse, release_pulse, busy);
    modport slave  (input  key_raw,
                    output key_level, press_pulse, release_pulse, busy);
`endif
endinterface

// File: rtl/key_debouncer.sv
// Active-low pushbutton debouncer: synchronizer, stable-time counter, 4-state filter FSM.
// Optional rejected-glitch counter enabled by defining KEY_DEBOUNCE_GLITCH_CNT_EN.
module key_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    key_debouncer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE_HI, FILT_LO, IDLE_LO, FILT_HI} state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_in;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_level, w_level_nxt;
    logic                   r_press, w_press_nxt;
    logic                   r_release, w_release_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   w_reject;

    // Reset to 1 so a held-down key still looks like a fresh press after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.key_raw};
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE_HI;
            r_cnt     <= '0;
            r_level   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Counter holds the number of consecutive candidate samples seen so far.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            IDLE_HI: begin
                if (!w_sync_in) begin
                    w_state_nxt = FILT_LO;
                    w_cnt_nxt   = LP_CNT_ONE;
                    w_busy_nxt  = 1'b1;
                end
            end
            FILT_LO: begin
                if (w_sync_in) begin
                    w_state_nxt = IDLE_HI;
                    w_reject    = 1'b1;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = IDLE_LO;
                    w_level_nxt = 1'b0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + LP_CNT_ONE;
                    w_busy_nxt = 1'b1;
                end
            end
            IDLE_LO: begin
                if (w_sync_in) begin
                    w_state_nxt = FILT_HI;
                    w_cnt_nxt   = LP_CNT_ONE;
                    w_busy_nxt  = 1'b1;
                end
            end
            FILT_HI: begin
                if (!w_sync_in) begin
                    w_state_nxt = IDLE_LO;
                    w_reject    = 1'b1;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt   = IDLE_HI;
                    w_level_nxt   = 1'b1;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + LP_CNT_ONE;
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE_HI;
                w_level_nxt = 1'b1;
            end
        endcase
    end

    assign bus.key_level     = r_level;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.busy          = r_busy;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;

    // Saturating so a noisy switch cannot make the count wrap back to small values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_glitch_cnt <= 8'd0;
        else if (w_reject && r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Conditions one raw, active-low mechanical pushbutton (DE10-Nano KEY/SW pin) into a clean, glitch-free level plus one-cycle press/release strobes. Sits directly upstream of the falling-edge pulse stretcher: `key_level` drives its `signal_in`. Contains a multi-flop synchronizer, a stable-time counter and a 4-state filter FSM.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `key_raw`; legal range 2..4.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronized samples required to accept a new level (20 ms at 50 MHz); legal range 2..2^24-1.
- `CNT_W`, 24: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_raw`  in  1  raw pin, asynchronous to `clk`, 0 = pressed.
- `key_level`  out  1  debounced level, 0 = pressed; registered.
- `press_pulse`  out  1  one-cycle strobe when `key_level` goes 1->0; registered.
- `release_pulse`  out  1  one-cycle strobe when `key_level` goes 0->1; registered.
- `busy`  out  1  high while a candidate transition is being filtered; registered.
- `glitch_cnt`  out  8  rejected-transition count; present only with `KEY_DEBOUNCE_GLITCH_CNT_EN`.

## Operation
- Reset (async assert, sync-safe deassert handled by the system): all sync flops = 1, state = `IDLE_HI`, counter = 0, `key_level` = 1, `press_pulse` = 0, `release_pulse` = 0, `busy` = 0, `glitch_cnt` = 0.
- `sync_in` = output of last synchronizer flop; only `sync_in` is used by the FSM.
- States: `IDLE_HI` (accepted 1), `FILT_LO` (candidate 0), `IDLE_LO` (accepted 0), `FILT_HI` (candidate 1).
- `IDLE_HI`: `sync_in`=0 -> `FILT_LO`, counter <= 1, `busy` <= 1. Else hold, counter <= 0.
- `FILT_LO`: `sync_in`=1 -> `IDLE_HI`, counter <= 0, `busy` <= 0, glitch recorded. `sync_in`=0 and counter = DEBOUNCE_CYCLES-1 -> `IDLE_LO`, `key_level` <= 0, `press_pulse` <= 1, `busy` <= 0, counter <= 0. Else counter <= counter+1.
- `IDLE_LO` / `FILT_HI`: mirror image with polarities swapped; acceptance asserts `release_pulse`.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Strobes are high for exactly one cycle and never simultaneously; at most one strobe per accepted transition.
- Any bounce back to the accepted level restarts filtering from counter = 1 on the next differing sample (full DEBOUNCE_CYCLES again).
- Reset mid-filter: outputs return to reset values immediately, no strobe emitted, candidate discarded.

## Timing
- Latency: a clean `key_raw` change meeting setup before rising edge E0 appears on `key_level` (and strobe) after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges total.
- `busy` rises SYNC_STAGES+1 edges after E0, falls in the same cycle `key_level` changes or the glitch is rejected.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach `key_level`.
- No combinational path from `key_raw` to any output.

## Configuration
- `KEY_DEBOUNCE_GLITCH_CNT_EN` defined: `glitch_cnt` port and an 8-bit counter exist; increments by 1 on every `FILT_*` -> `IDLE_*` rejection, saturates at 255, cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
(SYNC_STAGES=2, DEBOUNCE_CYCLES=8.)
- Reset with `key_raw`=0 held: during and after reset `key_level`=1, strobes 0, `busy`=0; `key_level` falls exactly 10 edges after first post-reset sampling edge, one `press_pulse`.
- Clean press at E0, held 20 cycles: `busy`=1 from E0+3, `key_level`=0 and `press_pulse`=1 after E0+9, `press_pulse`=0 next cycle.
- Bounce: `key_raw` low 5 cycles, high 2, low 20: no strobe during bounce, `key_level` falls 10 edges after final low edge, `glitch_cnt`=1.
- Release after accepted press: `key_raw` 0->1 held 20 -> single `release_pulse` 10 edges later, `key_level`=1.
- 300 sub-threshold glitches (3-cycle lows): `key_level` stays 1, no strobes, `glitch_cnt` saturates at 255.
- Assert `rst_n` at counter=5 in `FILT_LO`: outputs to reset values asynchronously, no `press_pulse`, filtering restarts after deassert.
